// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issue-side controller for the datapath ALU
//
// Purpose:
//   Accepts one ALU operation per request handshake and drives it into the ALU
//   as registered operands. The opcode and operands are held stable while the
//   class latency elapses. The controller then captures ZHI/ZLO and returns them
//   on the response handshake.
//   Illegal opcodes and divide-by-zero are screened here, so the ALU never sees them.
//
// Ports:
//   clock, reset_n             rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake (ready only while idle)
//   req_opcode/req_ra/req_rb   operation code and operands
//   alu_opcode/alu_ra/alu_rb   registered opcode and operands to the ALU
//   alu_zhi/alu_zlo            ALU results (combinational ALU)
//   rsp_valid/rsp_ready        response handshake to Z/HI/LO write-back
//   rsp_zhi/rsp_zlo            captured results
//   rsp_hilo_wr                result targets HI/LO (mul/div)
//   rsp_illegal, rsp_div0      screening flags

module alu_issue_ctrl #(
  parameter int SIMPLE_LAT = 1,
  parameter int MUL_LAT    = 4,
  parameter int DIV_LAT    = 34
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_opcode,
  input  logic [31:0] req_ra,
  input  logic [31:0] req_rb,
  output logic [4:0]  alu_opcode,
  output logic [31:0] alu_ra,
  output logic [31:0] alu_rb,
  input  logic [31:0] alu_zhi,
  input  logic [31:0] alu_zlo,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_zhi,
  output logic [31:0] rsp_zlo,
  output logic        rsp_hilo_wr,
  output logic        rsp_illegal,
  output logic        rsp_div0
);

  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_SHR = 5'b00101;
  localparam logic [4:0] OP_SHL = 5'b00110;
  localparam logic [4:0] OP_ROR = 5'b00111;
  localparam logic [4:0] OP_ROL = 5'b01000;
  localparam logic [4:0] OP_AND = 5'b01001;
  localparam logic [4:0] OP_OR  = 5'b01010;
  localparam logic [4:0] OP_MUL = 5'b01110;
  localparam logic [4:0] OP_DIV = 5'b01111;
  localparam logic [4:0] OP_NEG = 5'b10000;
  localparam logic [4:0] OP_NOT = 5'b10001;

  localparam int MAX_AB  = (SIMPLE_LAT > MUL_LAT) ? SIMPLE_LAT : MUL_LAT;
  localparam int MAX_LAT = (MAX_AB > DIV_LAT) ? MAX_AB : DIV_LAT;
  // The counter only ever holds LAT-1, so clog2(MAX_LAT) bits are enough.
  localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            req_legal;
  logic            req_is_div0;
  logic [CW-1:0]   req_cnt;
  logic            exec_hilo;

  // Classify the incoming opcode and pick the countdown start value.
  always_comb begin
    req_legal = 1'b1;
    req_cnt   = CW'(SIMPLE_LAT - 1);
    unique case (req_opcode)
      OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
      OP_AND, OP_OR, OP_NEG, OP_NOT: req_cnt = CW'(SIMPLE_LAT - 1);
      OP_MUL: req_cnt = CW'(MUL_LAT - 1);
      OP_DIV: req_cnt = CW'(DIV_LAT - 1);
      default: req_legal = 1'b0;
    endcase
  end

  assign req_is_div0 = (req_opcode == OP_DIV) && (req_rb == 32'd0);

  // alu_opcode is frozen during EXEC, so it identifies the class of the operation in flight.
  assign exec_hilo = (alu_opcode == OP_MUL) || (alu_opcode == OP_DIV);

  assign req_ready = (state == IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      alu_opcode  <= 5'b00000;
      alu_ra      <= 32'd0;
      alu_rb      <= 32'd0;
      rsp_valid   <= 1'b0;
      rsp_zhi     <= 32'd0;
      rsp_zlo     <= 32'd0;
      rsp_hilo_wr <= 1'b0;
      rsp_illegal <= 1'b0;
      rsp_div0    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            if (!req_legal) begin
              // Screened: the ALU inputs keep their previous operation.
              rsp_zhi     <= 32'd0;
              rsp_zlo     <= 32'd0;
              rsp_illegal <= 1'b1;
              rsp_div0    <= 1'b0;
              rsp_hilo_wr <= 1'b0;
              rsp_valid   <= 1'b1;
              state       <= RESP;
            end else if (req_is_div0) begin
              rsp_zhi     <= 32'd0;
              rsp_zlo     <= 32'd0;
              rsp_illegal <= 1'b0;
              rsp_div0    <= 1'b1;
              rsp_hilo_wr <= 1'b0;
              rsp_valid   <= 1'b1;
              state       <= RESP;
            end else begin
              alu_opcode <= req_opcode;
              alu_ra     <= req_ra;
              alu_rb     <= req_rb;
              cnt        <= req_cnt;
              state      <= EXEC;
            end
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            // Simple ops only produce ZLO; clear ZHI so write-back sees a clean value.
            rsp_zhi     <= exec_hilo ? alu_zhi : 32'd0;
            rsp_zlo     <= alu_zlo;
            rsp_hilo_wr <= exec_hilo;
            rsp_illegal <= 1'b0;
            rsp_div0    <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            // Results are left in place; only the qualifiers are cleared.
            rsp_valid   <= 1'b0;
            rsp_hilo_wr <= 1'b0;
            rsp_illegal <= 1'b0;
            rsp_div0    <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - self-checking bench for alu_issue_ctrl
module tb_alu_issue_ctrl;

  localparam int SIMPLE_LAT = 1;
  localparam int MUL_LAT    = 4;
  localparam int DIV_LAT    = 34;

  localparam logic [4:0] OP_ADD = 5'b00011, OP_SUB = 5'b00100, OP_SHR = 5'b00101;
  localparam logic [4:0] OP_SHL = 5'b00110, OP_ROR = 5'b00111, OP_ROL = 5'b01000;
  localparam logic [4:0] OP_AND = 5'b01001, OP_OR  = 5'b01010, OP_MUL = 5'b01110;
  localparam logic [4:0] OP_DIV = 5'b01111, OP_NEG = 5'b10000, OP_NOT = 5'b10001;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_opcode = '0;
  logic [31:0] req_ra = '0;
  logic [31:0] req_rb = '0;
  logic [4:0]  alu_opcode;
  logic [31:0] alu_ra, alu_rb;
  logic [31:0] alu_zhi, alu_zlo;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_zhi, rsp_zlo;
  logic        rsp_hilo_wr, rsp_illegal, rsp_div0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  alu_issue_ctrl #(.SIMPLE_LAT(SIMPLE_LAT), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_ra(req_ra), .req_rb(req_rb),
    .alu_opcode(alu_opcode), .alu_ra(alu_ra), .alu_rb(alu_rb),
    .alu_zhi(alu_zhi), .alu_zlo(alu_zlo),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_zhi(rsp_zhi), .rsp_zlo(rsp_zlo),
    .rsp_hilo_wr(rsp_hilo_wr), .rsp_illegal(rsp_illegal), .rsp_div0(rsp_div0)
  );

  // Combinational ALU stand-in. ZHI carries junk for simple ops so forced clearing is visible.
  always_comb begin
    alu_zhi = ~alu_ra;
    alu_zlo = 32'hDEAD_BEEF;
    case (alu_opcode)
      OP_ADD: alu_zlo = alu_ra + alu_rb;
      OP_SUB: alu_zlo = alu_ra - alu_rb;
      OP_SHR: alu_zlo = alu_ra >> alu_rb[4:0];
      OP_SHL: alu_zlo = alu_ra << alu_rb[4:0];
      OP_ROR: alu_zlo = (alu_ra >> alu_rb[4:0]) | (alu_ra << (6'd32 - {1'b0, alu_rb[4:0]}));
      OP_ROL: alu_zlo = (alu_ra << alu_rb[4:0]) | (alu_ra >> (6'd32 - {1'b0, alu_rb[4:0]}));
      OP_AND: alu_zlo = alu_ra & alu_rb;
      OP_OR:  alu_zlo = alu_ra | alu_rb;
      OP_MUL: {alu_zhi, alu_zlo} = {32'd0, alu_ra} * {32'd0, alu_rb};
      OP_DIV: begin
        alu_zlo = (alu_rb != 0) ? alu_ra / alu_rb : 32'hFFFF_FFFF;
        alu_zhi = (alu_rb != 0) ? alu_ra % alu_rb : 32'hFFFF_FFFF;
      end
      OP_NEG: alu_zlo = 32'd0 - alu_ra;
      OP_NOT: alu_zlo = ~alu_ra;
      default: ;
    endcase
  end

  // Reference: what write-back should receive, and after how many edges past acceptance.
  task automatic ref_model(input logic [4:0] op, input logic [31:0] ra, input logic [31:0] rb,
                           output logic ill, output logic d0, output logic hilo,
                           output logic [31:0] zhi, output logic [31:0] zlo, output int lat);
    logic [63:0] wide;
    int s;
    s = int'(rb[4:0]);
    ill = 0; d0 = 0; hilo = 0; zhi = 0; zlo = 0; lat = SIMPLE_LAT;
    case (op)
      OP_ADD: zlo = ra + rb;
      OP_SUB: zlo = ra - rb;
      OP_SHR: zlo = ra >> s;
      OP_SHL: zlo = ra << s;
      OP_ROR: begin wide = {ra, ra} >> s; zlo = wide[31:0]; end
      OP_ROL: begin wide = {ra, ra} << s; zlo = wide[63:32]; end
      OP_AND: zlo = ra & rb;
      OP_OR:  zlo = ra | rb;
      OP_NEG: zlo = -ra;
      OP_NOT: zlo = ~ra;
      OP_MUL: begin
        wide = 64'(ra) * 64'(rb);
        zhi = wide[63:32]; zlo = wide[31:0]; hilo = 1; lat = MUL_LAT;
      end
      OP_DIV: begin
        if (rb == 0) begin d0 = 1; lat = 0; end
        else begin zlo = ra / rb; zhi = ra % rb; hilo = 1; lat = DIV_LAT; end
      end
      default: begin ill = 1; lat = 0; end
    endcase
  endtask

  // Observations gathered by the driver, compared by each test.
  int          o_lat, o_ready_low;
  bit          o_timeout, o_alu_stable, o_hold_ok, o_drop_ok, o_retain;
  logic [31:0] o_zhi, o_zlo;
  logic        o_hilo, o_ill, o_div0;
  logic [4:0]  pre_op, snap_op;
  logic [31:0] pre_ra, snap_ra;

  // Drives one request. Hold is the number of extra cycles rsp_ready stays low.
  // During that time conflicting requests are offered.
  task automatic issue(input logic [4:0] op, input logic [31:0] ra, input logic [31:0] rb,
                       input int hold, input bit early);
    logic [31:0] snap_rb;
    @(negedge clock);
    pre_op = alu_opcode; pre_ra = alu_ra;
    req_opcode = op; req_ra = ra; req_rb = rb; req_valid = 1; rsp_ready = early;
    @(negedge clock);
    req_valid = 0;
    snap_op = alu_opcode; snap_ra = alu_ra; snap_rb = alu_rb;
    o_lat = 0; o_ready_low = 0; o_timeout = 0; o_alu_stable = 1; o_hold_ok = 1;
    while (!rsp_valid && o_lat < 200) begin
      if (!req_ready) o_ready_low++;
      if (alu_opcode !== snap_op || alu_ra !== snap_ra || alu_rb !== snap_rb) o_alu_stable = 0;
      @(negedge clock);
      o_lat++;
    end
    if (o_lat >= 200) o_timeout = 1;
    if (!req_ready) o_ready_low++;
    o_zhi = rsp_zhi; o_zlo = rsp_zlo; o_hilo = rsp_hilo_wr; o_ill = rsp_illegal; o_div0 = rsp_div0;
    for (int h = 0; h < hold; h++) begin
      req_valid = 1; req_opcode = OP_ADD; req_ra = $urandom; req_rb = $urandom;
      @(negedge clock);
      if (!req_ready) o_ready_low++;
      if (!rsp_valid || rsp_zhi !== o_zhi || rsp_zlo !== o_zlo || rsp_hilo_wr !== o_hilo ||
          rsp_illegal !== o_ill || rsp_div0 !== o_div0) o_hold_ok = 0;
      if (alu_opcode !== snap_op || alu_ra !== snap_ra || alu_rb !== snap_rb) o_alu_stable = 0;
    end
    req_valid = 0; rsp_ready = 1;
    @(negedge clock);
    o_drop_ok = !rsp_valid && req_ready && !rsp_illegal && !rsp_div0 && !rsp_hilo_wr;
    o_retain = (rsp_zlo === o_zlo) && (rsp_zhi === o_zhi);
    rsp_ready = 0;
  endtask

  task automatic test_reset();
    reset_n = 0;
    repeat (3) @(negedge clock);
    checks++;
    if (rsp_valid !== 0 || alu_opcode !== 0 || alu_ra !== 0 || alu_rb !== 0 ||
        rsp_zhi !== 0 || rsp_zlo !== 0 || rsp_hilo_wr !== 0 || rsp_illegal !== 0 || rsp_div0 !== 0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%0b op=%h ra=%h rb=%h zhi=%h zlo=%h flags=%b%b%b, required all zero",
               rsp_valid, alu_opcode, alu_ra, alu_rb, rsp_zhi, rsp_zlo, rsp_hilo_wr, rsp_illegal, rsp_div0);
    end
    reset_n = 1;
    @(negedge clock);
    checks++;
    if (req_ready !== 1) begin errors++; $display("FAIL reset_ready: req_ready=%0b required 1", req_ready); end
  endtask

  task automatic test_add();
    issue(OP_ADD, 32'd5, 32'd7, 0, 1);
    checks++; if (o_lat !== SIMPLE_LAT) begin errors++; $display("FAIL add_latency: got %0d required %0d", o_lat, SIMPLE_LAT); end
    checks++; if (o_zlo !== 32'd12) begin errors++; $display("FAIL add_zlo: got %h required %h", o_zlo, 32'd12); end
    checks++; if (o_zhi !== 0 || o_hilo !== 0) begin errors++; $display("FAIL add_zhi_hilo: got zhi=%h hilo=%0b required 0 0", o_zhi, o_hilo); end
    checks++; if (o_ready_low !== 2) begin errors++; $display("FAIL add_ready_low: got %0d cycles required 2", o_ready_low); end
    checks++; if (!o_drop_ok) begin errors++; $display("FAIL add_handshake: valid=%0b ready=%0b required 0 1", rsp_valid, req_ready); end
  endtask

  task automatic test_mul();
    issue(OP_MUL, 32'h10000, 32'h10000, 0, 0);
    checks++; if (o_lat !== MUL_LAT) begin errors++; $display("FAIL mul_latency: got %0d required %0d", o_lat, MUL_LAT); end
    checks++; if (o_zhi !== 1 || o_zlo !== 0) begin errors++; $display("FAIL mul_result: got zhi=%h zlo=%h required 1 0", o_zhi, o_zlo); end
    checks++; if (o_hilo !== 1) begin errors++; $display("FAIL mul_hilo: got %0b required 1", o_hilo); end
    checks++; if (!o_alu_stable || snap_op !== OP_MUL || snap_ra !== 32'h10000) begin
      errors++; $display("FAIL mul_alu_drive: stable=%0b op=%h ra=%h required 1 %h %h", o_alu_stable, snap_op, snap_ra, OP_MUL, 32'h10000);
    end
  endtask

  task automatic test_div0();
    issue(OP_DIV, 32'd9, 32'd0, 0, 0);
    checks++; if (snap_op !== pre_op || snap_ra !== pre_ra) begin
      errors++; $display("FAIL div0_alu_untouched: op=%h ra=%h required %h %h", snap_op, snap_ra, pre_op, pre_ra);
    end
    checks++; if (o_div0 !== 1 || o_ill !== 0 || o_hilo !== 0) begin
      errors++; $display("FAIL div0_flags: div0=%0b ill=%0b hilo=%0b required 1 0 0", o_div0, o_ill, o_hilo);
    end
    checks++; if (o_zhi !== 0 || o_zlo !== 0) begin errors++; $display("FAIL div0_result: zhi=%h zlo=%h required 0 0", o_zhi, o_zlo); end
    checks++; if (o_lat !== 0) begin errors++; $display("FAIL div0_latency: got %0d required 0", o_lat); end
  endtask

  task automatic test_illegal();
    issue(5'b11111, 32'h1234, 32'h5678, 0, 0);
    checks++; if (o_ill !== 1 || o_div0 !== 0 || o_zlo !== 0 || o_zhi !== 0) begin
      errors++; $display("FAIL illegal_rsp: ill=%0b div0=%0b zlo=%h zhi=%h required 1 0 0 0", o_ill, o_div0, o_zlo, o_zhi);
    end
    checks++; if (o_lat !== 0 || snap_op !== pre_op) begin
      errors++; $display("FAIL illegal_screen: lat=%0d op=%h required 0 %h", o_lat, snap_op, pre_op);
    end
    issue(OP_ADD, 32'd1, 32'd1, 0, 0);
    checks++; if (o_zlo !== 32'd2 || o_ill !== 0 || o_div0 !== 0 || o_hilo !== 0) begin
      errors++; $display("FAIL illegal_then_add: zlo=%h flags=%b%b%b required 2 000", o_zlo, o_ill, o_div0, o_hilo);
    end
  endtask

  task automatic test_backpressure();
    issue(OP_SUB, 32'd10, 32'd3, 5, 0);
    checks++; if (o_zlo !== 32'd7) begin errors++; $display("FAIL bp_zlo: got %h required 7", o_zlo); end
    checks++; if (!o_hold_ok || !o_alu_stable) begin
      errors++; $display("FAIL bp_hold: hold_ok=%0b alu_stable=%0b required 1 1", o_hold_ok, o_alu_stable);
    end
    checks++; if (o_ready_low !== SIMPLE_LAT + 1 + 5) begin
      errors++; $display("FAIL bp_ready_low: got %0d required %0d", o_ready_low, SIMPLE_LAT + 6);
    end
    checks++; if (!o_drop_ok || !o_retain) begin
      errors++; $display("FAIL bp_release: drop_ok=%0b retain=%0b zlo=%h required 1 1 7", o_drop_ok, o_retain, rsp_zlo);
    end
  endtask

  task automatic test_reset_mid_exec();
    bit seen;
    @(negedge clock);
    req_opcode = OP_DIV; req_ra = 32'd100; req_rb = 32'd7; req_valid = 1; rsp_ready = 1;
    @(negedge clock);
    req_valid = 0;
    repeat (10) @(negedge clock);
    #2 reset_n = 0;
    #1;
    checks++;
    if (rsp_valid !== 0 || alu_opcode !== 0 || alu_ra !== 0 || alu_rb !== 0 || rsp_zlo !== 0 || req_ready !== 1) begin
      errors++;
      $display("FAIL midreset_async: valid=%0b op=%h ra=%h rb=%h zlo=%h ready=%0b required 0 0 0 0 0 1",
               rsp_valid, alu_opcode, alu_ra, alu_rb, rsp_zlo, req_ready);
    end
    @(negedge clock);
    reset_n = 1;
    seen = 0;
    repeat (DIV_LAT + 20) begin
      @(negedge clock);
      if (rsp_valid) seen = 1;
    end
    rsp_ready = 0;
    checks++; if (seen) begin errors++; $display("FAIL midreset_no_rsp: rsp_valid seen=1 required 0"); end
    issue(OP_SHL, 32'd1, 32'd4, 0, 0);
    checks++; if (o_zlo !== 32'd16 || o_lat !== SIMPLE_LAT) begin
      errors++; $display("FAIL midreset_shl: zlo=%h lat=%0d required 10 %0d", o_zlo, o_lat, SIMPLE_LAT);
    end
  endtask

  task automatic test_random();
    logic [4:0]  op;
    logic [31:0] ra, rb, ezhi, ezlo;
    logic        eill, ed0, ehilo;
    int          elat, hold;
    bit          early;
    for (int n = 0; n < 40; n++) begin
      op = ($urandom_range(0, 4) == 0) ? 5'($urandom) : ((n % 3 == 0) ? OP_MUL : 5'($urandom_range(3, 17)));
      if (n % 7 == 0) op = OP_DIV;
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      early = $urandom_range(0, 1) == 1;
      hold = early ? 0 : $urandom_range(0, 3);
      ref_model(op, ra, rb, eill, ed0, ehilo, ezhi, ezlo, elat);
      issue(op, ra, rb, hold, early);
      checks++;
      if (o_timeout || o_lat !== elat) begin
        errors++; $display("FAIL rand_latency[%0d]: op=%b got %0d required %0d", n, op, o_lat, elat);
      end
      checks++;
      if (o_zhi !== ezhi || o_zlo !== ezlo) begin
        errors++; $display("FAIL rand_result[%0d]: op=%b ra=%h rb=%h got %h_%h required %h_%h", n, op, ra, rb, o_zhi, o_zlo, ezhi, ezlo);
      end
      checks++;
      if (o_ill !== eill || o_div0 !== ed0 || o_hilo !== ehilo) begin
        errors++; $display("FAIL rand_flags[%0d]: op=%b got %b%b%b required %b%b%b", n, op, o_ill, o_div0, o_hilo, eill, ed0, ehilo);
      end
      checks++;
      if (!o_alu_stable || !o_hold_ok || !o_drop_ok || o_ready_low !== elat + 1 + hold) begin
        errors++; $display("FAIL rand_protocol[%0d]: stable=%0b hold=%0b drop=%0b ready_low=%0d required 1 1 1 %0d",
                           n, o_alu_stable, o_hold_ok, o_drop_ok, o_ready_low, elat + 1 + hold);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_div0();
    test_illegal();
    test_backpressure();
    test_reset_mid_exec();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
